qdiv_fixed: RTL

Sequential signed fixed-point divider for the Q(I.F) datapath: computes quotient_o = a_i / b_i in the same I.F format used by the switchblock arithmetic, saturating to the representable range. It is the inverse operation of the combinational saturating multiplier. It is used wherever the datapath must normalise or rescale by a runtime value. It is a multi-cycle radix-2 restoring divider with a start/done handshake, so that no wide combinational divide sits in the datapath.

---
 rtl/qdiv_fixed_if.sv | 27 ++
 rtl/qdiv_fixed.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/qdiv_fixed_if.sv
// Handshake and operand/result bundle for the sequential fixed-point divider.
// Latency: none (wires only); the divider defines all timing.
// Backpressure: the requester may drive start_i only while ready_o is high.
interface qdiv_fixed_if #(
  parameter int W = 16
);
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic         overflow_o;
  logic         div_by_zero_o;

  // Divider side
  modport slave (
    input  start_i, a_i, b_i,
    output ready_o, done_o, quotient_o, overflow_o, div_by_zero_o
  );

  // Requester side
  modport master (
    output start_i, a_i, b_i,
    input  ready_o, done_o, quotient_o, overflow_o, div_by_zero_o
  );
endinterface

// File: rtl/qdiv_fixed.sv
// Signed saturating Q(I.F) divider, radix-2 restoring, one quotient bit per cycle.
// Latency: done_o high in the cycle after accept+N+1 edges (accept+1 for divide by zero).
// Backpressure: ready_o low during CALC; a start in the DONE cycle is accepted back-to-back.
package lib_switchblock_pkg;
  localparam int I = 4;   // integer bits including sign
  localparam int F = 12;  // fractional bits
endpackage

module qdiv_fixed
  import lib_switchblock_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  qdiv_fixed_if.slave bus
);

  localparam int W  = I + F;
  localparam int N  = W + F;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] LAST_IT  = CW'(N - 1);
  localparam logic [W-1:0]  MAX_VAL  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  // Magnitude limits expressed at quotient-register width
  localparam logic [N-1:0]  Q_POS_LIM = N'(MAX_VAL);
  localparam logic [N-1:0]  Q_NEG_LIM = N'(MIN_VAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Operand / iteration state
  logic          sign_q,  sign_d;
  logic          a_neg_q, a_neg_d;
  logic          dbz_q,   dbz_d;
  logic [W-1:0]  bmag_q,  bmag_d;
  logic [N-1:0]  num_q,   num_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic [N-1:0]  quot_q,  quot_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Registered results
  logic [W-1:0]  res_q,     res_d;
  logic          ovf_q,     ovf_d;
  logic          dbz_out_q, dbz_out_d;
  logic          done_q,    done_d;

  logic          accept;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    rem_shift;
  logic          rem_ge;

  // ready_o is high whenever no iteration is in progress
  assign accept = bus.start_i && (state_q != S_CALC);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: DONE lasts one cycle and can chain straight into the next request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d = (bus.b_i == '0) ? S_DONE : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == LAST_IT) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake from state, results straight from their registers
  always_comb begin
    bus.ready_o       = (state_q != S_CALC);
    bus.done_o        = done_q;
    bus.quotient_o    = res_q;
    bus.overflow_o    = ovf_q;
    bus.div_by_zero_o = dbz_out_q;
  end

  // Operand capture and one restoring-division step per CALC cycle
  always_comb begin
    sign_d  = sign_q;
    a_neg_d = a_neg_q;
    dbz_d   = dbz_q;
    bmag_d  = bmag_q;
    num_d   = num_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;

    // Negating the most negative value yields 2^(W-1), which is correct as unsigned
    a_mag = bus.a_i[W-1] ? -bus.a_i : bus.a_i;
    b_mag = bus.b_i[W-1] ? -bus.b_i : bus.b_i;

    // Remainder stays below |b|, so the shifted value needs one extra bit only
    rem_shift = {rem_q, num_q[N-1]};
    rem_ge    = (rem_shift >= {1'b0, bmag_q});

    if (accept) begin
      sign_d  = bus.a_i[W-1] ^ bus.b_i[W-1];
      a_neg_d = bus.a_i[W-1];
      dbz_d   = (bus.b_i == '0);
      bmag_d  = b_mag;
      num_d   = {a_mag, {F{1'b0}}};
      rem_d   = '0;
      quot_d  = '0;
      cnt_d   = '0;
    end else if (state_q == S_CALC) begin
      num_d = {num_q[N-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (rem_ge) begin
        // Difference is below |b|, so the low W bits are exact
        rem_d  = rem_shift[W-1:0] - bmag_q;
        quot_d = {quot_q[N-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift[W-1:0];
        quot_d = {quot_q[N-2:0], 1'b0};
      end
    end
  end

  // Result formatting: sign restore and saturation, latched when leaving DONE
  always_comb begin
    res_d     = res_q;
    ovf_d     = ovf_q;
    dbz_out_d = dbz_out_q;
    done_d    = 1'b0;
    if (state_q == S_DONE) begin
      done_d = 1'b1;
      if (dbz_q) begin
        res_d     = a_neg_q ? MIN_VAL : MAX_VAL;
        ovf_d     = 1'b0;
        dbz_out_d = 1'b1;
      end else if (!sign_q) begin
        dbz_out_d = 1'b0;
        if (quot_q > Q_POS_LIM) begin
          res_d = MAX_VAL;
          ovf_d = 1'b1;
        end else begin
          res_d = quot_q[W-1:0];
          ovf_d = 1'b0;
        end
      end else begin
        dbz_out_d = 1'b0;
        // A magnitude of exactly 2^(W-1) is still representable as min_val
        if (quot_q > Q_NEG_LIM) begin
          res_d = MIN_VAL;
          ovf_d = 1'b1;
        end else begin
          res_d = -quot_q[W-1:0];
          ovf_d = 1'b0;
        end
      end
    end
  end

  // Datapath and result registers; reset drops any in-flight division
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_q    <= 1'b0;
      a_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      bmag_q    <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      dbz_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sign_q    <= sign_d;
      a_neg_q   <= a_neg_d;
      dbz_q     <= dbz_d;
      bmag_q    <= bmag_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      dbz_out_q <= dbz_out_d;
      done_q    <= done_d;
    end
  end

endmodule
